// File: rtl/updown_counter_fsm.sv
// rtl/updown_counter_fsm.sv - W-bit up/down counter with limit, load and stop/wrap/saturate/bounce end modes
module updown_counter_fsm #(
   parameter int CNTR_WDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 act,
   input  logic                 up_dwn,
   input  logic                 load,
   input  logic [CNTR_WDTH-1:0] ld_val,
   input  logic [CNTR_WDTH-1:0] limit,
   input  logic [1:0]           mode,
   output logic [CNTR_WDTH-1:0] count,
   output logic                 ovrflw,
   output logic                 dir
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10,
      OVF  = 2'b11
   } state_t;

   localparam logic [1:0] MODE_STOP = 2'b00;
   localparam logic [1:0] MODE_WRAP = 2'b01;
   localparam logic [1:0] MODE_SAT  = 2'b10;
   localparam logic [1:0] MODE_BNC  = 2'b11;

   localparam logic [CNTR_WDTH-1:0] ZERO = '0;
   localparam logic [CNTR_WDTH-1:0] ONE  = {{(CNTR_WDTH-1){1'b0}}, 1'b1};

   state_t                 state;
   state_t                 state_nxt;
   logic [CNTR_WDTH-1:0]   count_nxt;
   logic                   ovrflw_nxt;
   logic                   dir_nxt;
   logic                   eff_dir;
   logic                   at_bound;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         count  <= '0;
         ovrflw <= 1'b0;
         dir    <= 1'b1;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         ovrflw <= ovrflw_nxt;
         dir    <= dir_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      ovrflw_nxt = ovrflw;
      dir_nxt    = dir;

      // Bounce keeps its own direction once running; every other mode follows up_dwn live.
      eff_dir  = (mode == MODE_BNC && state != IDLE) ? dir : up_dwn;
      at_bound = eff_dir ? (count >= limit) : (count == ZERO);

      if (load) begin
         count_nxt  = (ld_val > limit) ? limit : ld_val;
         ovrflw_nxt = 1'b0;
         dir_nxt    = up_dwn;
         state_nxt  = IDLE;
      end else if (state != OVF) begin
         ovrflw_nxt = 1'b0;
         if (mode != MODE_BNC || act) begin
            dir_nxt = eff_dir;
         end
         if (!act) begin
            state_nxt = IDLE;
         end else if (!at_bound) begin
            count_nxt = eff_dir ? count + ONE : count - ONE;
            state_nxt = eff_dir ? UP : DOWN;
         end else begin
            ovrflw_nxt = 1'b1;
            state_nxt  = eff_dir ? UP : DOWN;
            case (mode)
               MODE_STOP: begin
                  count_nxt = eff_dir ? limit : ZERO;
                  state_nxt = OVF;
               end
               MODE_WRAP: count_nxt = eff_dir ? ZERO : limit;
               MODE_SAT:  count_nxt = eff_dir ? limit : ZERO;
               MODE_BNC: begin
                  dir_nxt   = ~eff_dir;
                  // A zero-length range has nowhere to bounce to, so it pins at 0.
                  if (limit == ZERO) begin
                     count_nxt = ZERO;
                  end else begin
                     count_nxt = eff_dir ? limit - ONE : ONE;
                  end
                  state_nxt = eff_dir ? DOWN : UP;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_updown_counter_fsm.sv
// tb/tb_updown_counter_fsm.sv - scoreboard bench for updown_counter_fsm against a behavioural model
module tb_updown_counter_fsm;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         act = 1'b0;
   logic         up_dwn = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] ld_val = '0;
   logic [W-1:0] limit = '1;
   logic [1:0]   mode = 2'b00;
   logic [W-1:0] count;
   logic         ovrflw;
   logic         dir;

   always #5 clk = ~clk;

   updown_counter_fsm #(.CNTR_WDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .act    (act),
      .up_dwn (up_dwn),
      .load   (load),
      .ld_val (ld_val),
      .limit  (limit),
      .mode   (mode),
      .count  (count),
      .ovrflw (ovrflw),
      .dir    (dir)
   );

   typedef struct {
      logic [W-1:0] cnt;
      logic         ovf;
      logic         dr;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   // Reference model: plain integers, running = "a step happened last edge".
   int m_cnt = 0;
   bit m_ovf = 0;
   bit m_dir = 1;
   bit m_frozen = 0;
   bit m_running = 0;

   task automatic model_edge();
      int  lim;
      int  md;
      bit  d;
      bit  hit;
      lim = int'(limit);
      md  = int'(mode);
      if (!rst) begin
         m_cnt = 0; m_ovf = 0; m_dir = 1; m_frozen = 0; m_running = 0;
      end else if (load) begin
         m_cnt = (int'(ld_val) > lim) ? lim : int'(ld_val);
         m_ovf = 0; m_dir = up_dwn; m_frozen = 0; m_running = 0;
      end else if (!m_frozen) begin
         if (md != 3) m_dir = up_dwn;
         m_ovf = 0;
         if (!act) begin
            m_running = 0;
         end else begin
            if (md == 3 && !m_running) m_dir = up_dwn;
            m_running = 1;
            d   = m_dir;
            hit = d ? (m_cnt >= lim) : (m_cnt == 0);
            if (!hit) begin
               m_cnt = d ? m_cnt + 1 : m_cnt - 1;
            end else begin
               m_ovf = 1;
               if (md == 0) begin
                  m_cnt = d ? lim : 0;
                  m_frozen = 1;
               end else if (md == 1) begin
                  m_cnt = d ? 0 : lim;
               end else if (md == 2) begin
                  m_cnt = d ? lim : 0;
               end else begin
                  m_cnt = (lim == 0) ? 0 : (d ? lim - 1 : 1);
                  m_dir = !d;
               end
            end
         end
      end
   endtask

   task automatic drive(input bit r, input bit a, input bit u, input bit l,
                        input int lv, input int lim, input int md);
      @(negedge clk);
      rst    = r;
      act    = a;
      up_dwn = u;
      load   = l;
      ld_val = W'(lv);
      limit  = W'(lim);
      mode   = 2'(md);
      @(posedge clk);
      cyc++;
      model_edge();
      sb.push_back('{cnt: W'(m_cnt), ovf: m_ovf, dr: m_dir, cyc: cyc});
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (count !== e.cnt) begin
            errors++;
            $display("FAIL cycle %0d count: got %0d expected %0d", e.cyc, count, e.cnt);
         end
         checks++;
         if (ovrflw !== e.ovf) begin
            errors++;
            $display("FAIL cycle %0d ovrflw: got %b expected %b", e.cyc, ovrflw, e.ovf);
         end
         checks++;
         if (dir !== e.dr) begin
            errors++;
            $display("FAIL cycle %0d dir: got %b expected %b", e.cyc, dir, e.dr);
         end
      end
   end

   initial begin
      // Reset, then old-block equivalence: stop mode, full range, up for 40 cycles.
      drive(0, 1, 1, 1, 9, 31, 0);
      drive(0, 0, 1, 0, 0, 31, 0);
      for (int i = 0; i < 40; i++) drive(1, 1, (i < 32) ? 1'b1 : 1'(i), 0, 0, 31, 0);

      // Wrap down inside a limit.
      drive(1, 0, 0, 1, 2, 9, 1);
      for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 9, 1);

      // Saturate at the top, then step back down.
      drive(1, 0, 1, 1, 4, 5, 2);
      for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 0, 5, 2);
      drive(1, 1, 0, 0, 0, 5, 2);

      // Bounce with up_dwn scrambled after the run starts.
      drive(1, 0, 1, 1, 0, 3, 3);
      for (int i = 0; i < 8; i++) drive(1, 1, (i < 1) ? 1'b1 : 1'($urandom), 0, 0, 3, 3);

      // Priority: load beats act and is clamped; reset beats load; reset mid-count.
      drive(1, 1, 1, 1, 20, 15, 1);
      drive(0, 1, 1, 1, 5, 15, 1);
      for (int i = 0; i < 7; i++) drive(1, 1, 1, 0, 0, 31, 1);
      drive(0, 1, 1, 0, 0, 31, 1);

      // OVF hold across a mode change, then release by load.
      drive(1, 0, 1, 1, 2, 4, 0);
      for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 0, 4, 0);
      for (int i = 0; i < 3; i++) drive(1, 1, 1'(i), 0, 0, 4, 1);
      drive(1, 1, 1, 1, 3, 4, 1);
      for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0, 4, 1);

      // Bounce with degenerate ranges.
      drive(1, 0, 1, 1, 0, 0, 3);
      for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 0, 0, 3);
      drive(1, 0, 0, 1, 1, 1, 3);
      for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 1, 3);

      // Random soak.
      begin
         int lim_r;
         int md_r;
         lim_r = 12;
         md_r  = 1;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29) == 0) lim_r = $urandom_range(31);
            if ($urandom_range(39) == 0) md_r = $urandom_range(3);
            drive($urandom_range(99) != 0, $urandom_range(4) != 0, 1'($urandom),
                  $urandom_range(19) == 0, $urandom_range(31), lim_r, md_r);
         end
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d entries left expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
